// File: rtl/game_status_pkg.sv
// game_status_pkg: shared state encoding, default round constants and kill popcount. Rev 1.0
`default_nettype none

package game_status_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIC  = 2'd1,
    INFINITY = 2'd2,
    OVER     = 2'd3
  } game_state_t;

  localparam int LIVES_INIT_DEF     = 3;
  localparam int ENEMY_TOTAL_DEF    = 20;
  localparam int SCORE_PER_KILL_DEF = 100;
  localparam int SCORE_MAX_DEF      = 9999;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_status_tracker_game_sec_tick.sv
// game_sec_tick: free-running seconds prescaler, one-cycle tick every TICKS_PER_SEC clocks. Rev 1.0
`default_nettype none

module game_sec_tick #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  assign tick = !clr && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_status_tracker.sv
// game_status_tracker: round lives/score/enemy/time bookkeeping and gameover requests.
// Optional infinity-mode time limit enabled by defining GAME_TIMER_EN. Rev 1.0
`default_nettype none

module game_status_tracker
  import game_status_pkg::*;
#(
  parameter int LIVES_INIT     = LIVES_INIT_DEF,
  parameter int ENEMY_TOTAL    = ENEMY_TOTAL_DEF,
  parameter int SCORE_PER_KILL = SCORE_PER_KILL_DEF,
  parameter int SCORE_MAX      = SCORE_MAX_DEF,
  parameter int TIME_LIMIT     = 120,
  parameter int TICKS_PER_SEC  = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_game_classic,
  input  logic        enable_game_infinity,
  input  logic        mytank_hit,
  input  logic [3:0]  enytank_kill,
  input  logic        reward_life,
  output logic        gameover_classic,
  output logic        gameover_infinity,
  output logic        game_won,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [5:0]  enemies_left,
  output logic [7:0]  time_left
);

  localparam logic [2:0]  LIVES_RELOAD = 3'(LIVES_INIT);
  localparam logic [5:0]  ENEMY_RELOAD = 6'(ENEMY_TOTAL);
`ifdef GAME_TIMER_EN
  localparam logic [7:0]  TIME_RELOAD  = 8'(TIME_LIMIT);
  localparam bit          TIMER_ON     = 1'b1;
`else
  localparam logic [7:0]  TIME_RELOAD  = 8'd0;
  localparam bit          TIMER_ON     = 1'b0;
`endif

  game_state_t state, state_nx;
  logic        go_c_nx, go_i_nx, won_nx;
  logic [2:0]  lives_nx, lives_upd, kills;
  logic [15:0] score_nx, score_upd;
  logic [5:0]  enemies_nx, enemies_upd;
  logic [7:0]  time_nx, time_upd;
  logic [31:0] score_sum;
  logic        sec_tick;

`ifdef GAME_TIMER_EN
  game_sec_tick #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != INFINITY),
    .tick (sec_tick)
  );
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = (TIME_LIMIT == 0) ^ (TICKS_PER_SEC == 0);
  assign sec_tick = 1'b0;
`endif

  // Saturating candidate updates; the FSM decides which ones are committed.
  always_comb begin
    kills       = popcount4(enytank_kill);
    score_sum   = 32'(score) + 32'(kills) * 32'(SCORE_PER_KILL);
    score_upd   = (score_sum > 32'(SCORE_MAX)) ? 16'(SCORE_MAX) : score_sum[15:0];
    enemies_upd = (enemies_left > 6'(kills)) ? enemies_left - 6'(kills) : 6'd0;
    time_upd    = (sec_tick && time_left != 8'd0) ? time_left - 8'd1 : time_left;
    lives_upd   = lives;
    if (mytank_hit && !reward_life) begin
      lives_upd = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
    end else if (reward_life && !mytank_hit) begin
      lives_upd = (lives == 3'd7) ? 3'd7 : lives + 3'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    go_c_nx    = gameover_classic;
    go_i_nx    = gameover_infinity;
    won_nx     = game_won;
    lives_nx   = lives;
    score_nx   = score;
    enemies_nx = enemies_left;
    time_nx    = time_left;
    case (state)
      IDLE: begin
        if (enable_game_classic || enable_game_infinity) begin
          state_nx   = enable_game_classic ? CLASSIC : INFINITY;
          go_c_nx    = 1'b0;
          go_i_nx    = 1'b0;
          won_nx     = 1'b0;
          lives_nx   = LIVES_RELOAD;
          score_nx   = 16'd0;
          enemies_nx = ENEMY_RELOAD;
          time_nx    = TIME_RELOAD;
        end
      end
      CLASSIC: begin
        if (!enable_game_classic) begin
          state_nx = IDLE;
        end else begin
          lives_nx   = lives_upd;
          score_nx   = score_upd;
          enemies_nx = enemies_upd;
          if (lives_upd == 3'd0 || enemies_upd == 6'd0) begin
            state_nx = OVER;
            go_c_nx  = 1'b1;
            won_nx   = (lives_upd != 3'd0);
          end
        end
      end
      INFINITY: begin
        if (!enable_game_infinity) begin
          state_nx = IDLE;
        end else begin
          lives_nx = lives_upd;
          score_nx = score_upd;
          time_nx  = time_upd;
          if (lives_upd == 3'd0 || (TIMER_ON && time_upd == 8'd0)) begin
            state_nx = OVER;
            go_i_nx  = 1'b1;
            won_nx   = (lives_upd != 3'd0);
          end
        end
      end
      OVER: begin
        if (!enable_game_classic && !enable_game_infinity) begin
          state_nx = IDLE;
          go_c_nx  = 1'b0;
          go_i_nx  = 1'b0;
          won_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      gameover_classic  <= 1'b0;
      gameover_infinity <= 1'b0;
      game_won          <= 1'b0;
      lives             <= LIVES_RELOAD;
      score             <= 16'd0;
      enemies_left      <= ENEMY_RELOAD;
      time_left         <= TIME_RELOAD;
    end else begin
      state             <= state_nx;
      gameover_classic  <= go_c_nx;
      gameover_infinity <= go_i_nx;
      game_won          <= won_nx;
      lives             <= lives_nx;
      score             <= score_nx;
      enemies_left      <= enemies_nx;
      time_left         <= time_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_status_tracker.sv
// tb_game_status_tracker: directed self-checking bench for game_status_tracker. Rev 1.0
`default_nettype none

module tb_game_status_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_c, en_i, hit, reward;
  logic [3:0]  kill;
  logic        go_c, go_i, won;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [5:0]  enemies;
  logic [7:0]  time_left;

  int n_cmp = 0;
  int n_err = 0;

`ifdef GAME_TIMER_EN
  localparam int EXP_TIME = 2;
`else
  localparam int EXP_TIME = 0;
`endif

  game_status_tracker #(
    .TIME_LIMIT    (2),
    .TICKS_PER_SEC (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable_game_classic  (en_c),
    .enable_game_infinity (en_i),
    .mytank_hit           (hit),
    .enytank_kill         (kill),
    .reward_life          (reward),
    .gameover_classic     (go_c),
    .gameover_infinity    (go_i),
    .game_won             (won),
    .lives                (lives),
    .score                (score),
    .enemies_left         (enemies),
    .time_left            (time_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; inputs and samples both sit 1 time unit after it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic h, input logic r, input logic [3:0] k);
    hit = h; reward = r; kill = k;
    step();
    hit = 1'b0; reward = 1'b0; kill = 4'd0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_go_c"}, int'(go_c), 0);
    check({tag, "_go_i"}, int'(go_i), 0);
    check({tag, "_won"}, int'(won), 0);
    check({tag, "_lives"}, int'(lives), 3);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_enemies"}, int'(enemies), 20);
    check({tag, "_time"}, int'(time_left), EXP_TIME);
  endtask

  initial begin
    rst = 1'b1; en_c = 1'b0; en_i = 1'b0; hit = 1'b0; reward = 1'b0; kill = 4'd0;
    #1;
    step(2);
    rst = 1'b0;
    step();
    check_reset("reset");

    // Classic win by 20 single kills
    en_c = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      pulse(1'b0, 1'b0, 4'(1 << (i % 4)));
      if (i == 9) begin
        check("win_mid_score", int'(score), 1000);
        check("win_mid_go", int'(go_c), 0);
      end
    end
    check("win_score", int'(score), 2000);
    check("win_enemies", int'(enemies), 0);
    check("win_go_c", int'(go_c), 1);
    check("win_won", int'(won), 1);
    step();
    check("win_hold_go_c", int'(go_c), 1);
    en_c = 1'b0;
    step();
    check("win_clear_go_c", int'(go_c), 0);
    check("win_idle_score", int'(score), 2000);

    // Classic loss by 3 hits
    en_c = 1'b1;
    step();
    check("loss_reload_score", int'(score), 0);
    check("loss_reload_enemies", int'(enemies), 20);
    pulse(1'b1, 1'b0, 4'd0);
    pulse(1'b1, 1'b0, 4'd0);
    check("loss_lives1", int'(lives), 1);
    check("loss_go_early", int'(go_c), 0);
    pulse(1'b1, 1'b0, 4'd0);
    check("loss_lives0", int'(lives), 0);
    check("loss_go_c", int'(go_c), 1);
    check("loss_won", int'(won), 0);
    pulse(1'b0, 1'b1, 4'b1111);
    check("loss_frozen_score", int'(score), 0);
    check("loss_frozen_lives", int'(lives), 0);
    en_c = 1'b0;
    step();
    check("loss_clear_go_c", int'(go_c), 0);
    check("loss_idle_lives", int'(lives), 0);
    pulse(1'b0, 1'b1, 4'b1111);
    check("idle_ignore_score", int'(score), 0);

    // Multi-kill, cancel, lives saturation
    en_c = 1'b1;
    step();
    pulse(1'b0, 1'b0, 4'b1111);
    check("multi_score", int'(score), 400);
    check("multi_enemies", int'(enemies), 16);
    pulse(1'b1, 1'b1, 4'b0000);
    check("cancel_lives", int'(lives), 3);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 4'd0);
    check("sat_lives", int'(lives), 7);
    check("sat_go_c", int'(go_c), 0);
    en_c = 1'b0;
    step();

    // Collision: lives and enemies reach 0 together
    en_c = 1'b1;
    step();
    pulse(1'b1, 1'b0, 4'd0);
    pulse(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0, 4'b1111);
    check("coll_pre_enemies", int'(enemies), 4);
    check("coll_pre_go", int'(go_c), 0);
    pulse(1'b1, 1'b0, 4'b1111);
    check("coll_lives", int'(lives), 0);
    check("coll_enemies", int'(enemies), 0);
    check("coll_go_c", int'(go_c), 1);
    check("coll_won", int'(won), 0);
    en_c = 1'b0;
    step();

`ifdef GAME_TIMER_EN
    // Infinity time limit: 2 s at 4 cycles per second
    en_i = 1'b1;
    step();
    check("tmr_start", int'(time_left), 2);
    step(7);
    check("tmr_7_time", int'(time_left), 1);
    check("tmr_7_go", int'(go_i), 0);
    step();
    check("tmr_time0", int'(time_left), 0);
    check("tmr_go_i", int'(go_i), 1);
    check("tmr_won", int'(won), 1);
    check("tmr_go_c", int'(go_c), 0);
    en_i = 1'b0;
    step();
    check("tmr_clear", int'(go_i), 0);
`else
    // Infinity without timer: score saturation, enemies held, no time end
    en_i = 1'b1;
    step();
    for (int i = 0; i < 24; i++) pulse(1'b0, 1'b0, 4'b1111);
    pulse(1'b0, 1'b0, 4'b0111);
    check("inf_score_9900", int'(score), 9900);
    pulse(1'b0, 1'b0, 4'b1111);
    check("inf_score_sat", int'(score), 9999);
    check("inf_enemies", int'(enemies), 20);
    check("inf_time", int'(time_left), 0);
    check("inf_go_i", int'(go_i), 0);
    pulse(1'b1, 1'b0, 4'd0);
    check("inf_lives", int'(lives), 2);
    en_i = 1'b0;
    step();
    check("inf_drop_go_i", int'(go_i), 0);
`endif

    // Both enables: classic wins priority; then reset mid-round
    en_c = 1'b1; en_i = 1'b1;
    step();
    pulse(1'b0, 1'b0, 4'b0001);
    check("prio_enemies", int'(enemies), 19);
    check("prio_score", int'(score), 100);
    rst = 1'b1;
    step();
    rst = 1'b0; en_c = 1'b0; en_i = 1'b0;
    check_reset("midrst");
    step();
    check("midrst_idle_enemies", int'(enemies), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/game_status_tracker.md
# game_status_tracker

Tracks the live state of a running round (lives, score, enemies remaining, optional time limit) and raises the `gameover_classic` / `gameover_infinity` requests consumed by the game-mode sequencer. It consumes that sequencer's `enable_game_classic` / `enable_game_infinity` outputs plus hit, kill and reward event pulses from the tank/bullet blocks. It drives the counters shown on the score display.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives loaded at round start (1..7).
- `ENEMY_TOTAL`, 20: enemies to destroy to win classic mode (1..63).
- `SCORE_PER_KILL`, 100: score added per destroyed enemy.
- `SCORE_MAX`, 9999: score saturation value (4-digit display).
- `TIME_LIMIT`, 120: infinity-mode round length in seconds (1..255). Used only with the timer option.
- `TICKS_PER_SEC`, 100_000_000: `clk` cycles per second. Used only with the timer option.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `enable_game_classic`  in  1  classic round running (from mode sequencer)
- `enable_game_infinity`  in  1  infinity round running (from mode sequencer)
- `mytank_hit`  in  1  one-cycle pulse: player tank destroyed
- `enytank_kill`  in  4  one-cycle pulses, one bit per enemy tank destroyed; any combination of bits may be set
- `reward_life`  in  1  one-cycle pulse: extra-life pickup
- `gameover_classic`  out  1  classic round finished (level)
- `gameover_infinity`  out  1  infinity round finished (level)
- `game_won`  out  1  valid while a gameover output is high; 1 = win, 0 = loss
- `lives`  out  3  remaining lives
- `score`  out  16  binary score
- `enemies_left`  out  6  classic enemies remaining
- `time_left`  out  8  seconds remaining; constant 0 when the timer option is compiled out

## Operation
- The state machine has four states: IDLE, CLASSIC, INFINITY, OVER.
- **Reset.** State goes to IDLE. Outputs reset to: `gameover_*`=0, `game_won`=0, `lives`=LIVES_INIT, `score`=0, `enemies_left`=ENEMY_TOTAL, `time_left`=TIME_LIMIT (or 0 when the timer option is compiled out).
- **IDLE.**
  - Event inputs are ignored and counters hold their values, so the last round stays visible.
  - If `enable_game_classic`=1, go to CLASSIC. Classic has priority when both enables are high.
  - Else if `enable_game_infinity`=1, go to INFINITY.
  - On either transition, reload all counters to their reset values. Events arriving in the transition cycle are ignored.
- **CLASSIC / INFINITY counter rules:**
  - `k` = popcount(`enytank_kill`), range 0..4.
  - `score` += k*SCORE_PER_KILL, saturating at SCORE_MAX.
  - `lives` += `reward_life` − `mytank_hit`, floored at 0 and saturating at 7. A hit and a reward in the same cycle cancel.
  - CLASSIC only: `enemies_left` −= k, floored at 0. In INFINITY it holds.
- **End conditions.** These are evaluated on the next-state counter values.
  - CLASSIC: if lives reaches 0, the round is lost. Otherwise, if `enemies_left` reaches 0, the round is won. If both happen in the same cycle, it is a loss.
  - INFINITY: if lives reaches 0, the round is lost. With the timer option, `time_left` reaching 0 is a win. If both happen in the same cycle, it is a loss.
  - On an end condition: go to OVER and assert the matching `gameover_*` and `game_won`.
- **Enable dropped mid-round.** If the state's enable goes low (sequencer reset), go to IDLE with no gameover.
- **OVER.**
  - Counters are frozen and events are ignored.
  - `gameover_*` and `game_won` are held until both enables are low. Then go to IDLE and clear them.
  - This lets the sequencer sample the level at any time, then drop its enables to acknowledge.

## Timing
- All outputs are registered. An event sampled at edge N updates the counters at edge N, and the counters are visible during cycle N+1.
- An end condition caused by the event at edge N asserts `gameover_*` in the same cycle N+1 that shows the final counters. Event-to-gameover latency is 1 cycle.
- The sequencer removes its enable 1 cycle after it sees gameover. The tracker then clears gameover 1 cycle after both enables are low.
- Round start: an enable going high at edge N reloads the counters, and the first counted event is at edge N+1.

## Configuration
- `GAME_TIMER_EN` **defined:**
  - INFINITY keeps a prescaler counting 0..TICKS_PER_SEC−1 that produces a 1-cycle tick.
  - Each tick decrements `time_left`.
  - The prescaler and `time_left` reload on round entry.
  - Reaching 0 ends the round as a win.
- `GAME_TIMER_EN` **undefined:** there is no prescaler, `time_left` is tied to 0, and infinity ends only on loss of lives.

## Structure
- Shared package `game_status_pkg` holds:
  - the state enum (IDLE=0, CLASSIC=1, INFINITY=2, OVER=3);
  - default constants for LIVES_INIT, ENEMY_TOTAL, SCORE_PER_KILL and SCORE_MAX.
- Sub-module `game_sec_tick`: parameterised by TICKS_PER_SEC, with inputs `clk`, `rst` and `clr`, and output `tick`. It is instantiated only under `GAME_TIMER_EN`.

## Test plan
- Classic, defaults: 20 single-bit kills → `score`=2000, `enemies_left`=0, `gameover_classic`=1 and `game_won`=1 one cycle after the 20th kill.
- Classic: 3 `mytank_hit` pulses → `lives`=0, `gameover_classic`=1, `game_won`=0. Drop the enable → gameover clears the following cycle and the counters stay frozen.
- `enytank_kill`=4'b1111 in one cycle → `score`+=400 and `enemies_left`−=4. At `score`=9900, a kill of 4 saturates at 9999.
- A hit and a reward in the same cycle → `lives` unchanged. 5 rewards starting from 3 → `lives`=7. The lives-to-0 and enemies-to-0 collision → loss.
- Infinity with `GAME_TIMER_EN`, TICKS_PER_SEC=4, TIME_LIMIT=2 → `gameover_infinity`=1 and `game_won`=1 after 8 cycles. Without the macro → no gameover and `time_left`=0.
- `rst` asserted mid-CLASSIC → the next cycle is IDLE with all outputs at reset values. Both enables high in IDLE → CLASSIC is entered.
